// File: rtl/time_set_ctrl.sv
// Mode/setting controller for the HH:MM:SS clock: walks RUN and the three set modes,
// turns the increment button into single or auto-repeat pulses, and drives digit blinking.
module time_set_ctrl #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int BLINK_HALF   = 25_000_000,
    parameter int TIMEOUT      = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic [1:0] mode,
    output logic       inc_h,
    output logic       inc_m,
    output logic       inc_s,
    output logic       blank_h,
    output logic       blank_m,
    output logic       blank_s
);

    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int RW = $clog2(REPEAT_RATE + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } mode_t;

    mode_t         mode_q, mode_d;
    logic          btn_mode_q, btn_inc_q;
    logic          hold_active_q, hold_active_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rate_q, rate_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          run_en_q, run_en_d;
    logic          inc_h_q, inc_h_d, inc_m_q, inc_m_d, inc_s_q, inc_s_d;
    logic          blank_h_q, blank_h_d, blank_m_q, blank_m_d, blank_s_q, blank_s_d;

    logic edge_mode, edge_inc, in_set, timeout_hit, rep_fire, inc_req;

    always_comb begin
        edge_mode   = btn_mode & ~btn_mode_q;
        edge_inc    = btn_inc & ~btn_inc_q;
        in_set      = (mode_q != RUN);
        timeout_hit = in_set && (idle_q == IW'(TIMEOUT));

        mode_d = mode_q;
        if (edge_mode) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end else if (timeout_hit) begin
            mode_d = RUN;
        end

        // Hold counter only runs after a fresh rising edge seen in a set mode;
        // a mode press or timeout parks it until the next such edge.
        rep_fire      = 1'b0;
        hold_active_d = hold_active_q;
        hold_d        = hold_q;
        rate_d        = rate_q;
        if (!btn_inc || edge_mode || timeout_hit || !in_set) begin
            hold_active_d = 1'b0;
            hold_d        = '0;
            rate_d        = '0;
        end else if (edge_inc) begin
            hold_active_d = 1'b1;
            hold_d        = HW'(1);
            rate_d        = '0;
        end else if (hold_active_q) begin
            if (hold_q != HW'(REPEAT_DELAY)) begin
                hold_d = hold_q + HW'(1);
            end else if (rate_q == '0 || rate_q == RW'(REPEAT_RATE)) begin
                rep_fire = 1'b1;
                rate_d   = RW'(1);
            end else begin
                rate_d = rate_q + RW'(1);
            end
        end

        inc_req = in_set && !edge_mode && !timeout_hit && (edge_inc || rep_fire);
        inc_h_d = inc_req && (mode_q == SET_H);
        inc_m_d = inc_req && (mode_q == SET_M);
        inc_s_d = inc_req && (mode_q == SET_S);

        idle_d = idle_q;
        if (!in_set || edge_mode || edge_inc || btn_inc || timeout_hit) begin
            idle_d = '0;
        end else if (idle_q != IW'(TIMEOUT)) begin
            idle_d = idle_q + IW'(1);
        end

        // Restarting the phase on a mode change shows the newly selected field first.
        blink_d = blink_q + BW'(1);
        phase_d = phase_q;
        if (mode_d != mode_q) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (blink_q == BW'(BLINK_HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end

        run_en_d  = (mode_d == RUN);
        blank_h_d = phase_d && (mode_d == SET_H);
        blank_m_d = phase_d && (mode_d == SET_M);
        blank_s_d = phase_d && (mode_d == SET_S);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q        <= RUN;
            btn_mode_q    <= 1'b0;
            btn_inc_q     <= 1'b0;
            hold_active_q <= 1'b0;
            hold_q        <= '0;
            rate_q        <= '0;
            idle_q        <= '0;
            blink_q       <= '0;
            phase_q       <= 1'b0;
            run_en_q      <= 1'b1;
            inc_h_q       <= 1'b0;
            inc_m_q       <= 1'b0;
            inc_s_q       <= 1'b0;
            blank_h_q     <= 1'b0;
            blank_m_q     <= 1'b0;
            blank_s_q     <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            btn_mode_q    <= btn_mode;
            btn_inc_q     <= btn_inc;
            hold_active_q <= hold_active_d;
            hold_q        <= hold_d;
            rate_q        <= rate_d;
            idle_q        <= idle_d;
            blink_q       <= blink_d;
            phase_q       <= phase_d;
            run_en_q      <= run_en_d;
            inc_h_q       <= inc_h_d;
            inc_m_q       <= inc_m_d;
            inc_s_q       <= inc_s_d;
            blank_h_q     <= blank_h_d;
            blank_m_q     <= blank_m_d;
            blank_s_q     <= blank_s_d;
        end
    end

    assign mode    = mode_q;
    assign run_en  = run_en_q;
    assign inc_h   = inc_h_q;
    assign inc_m   = inc_m_q;
    assign inc_s   = inc_s_q;
    assign blank_h = blank_h_q;
    assign blank_m = blank_m_q;
    assign blank_s = blank_s_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short timing parameters; expected output
// vectors are queued as each step is driven and checked one cycle later.
module tb_time_set_ctrl;

    localparam int RD = 8;
    localparam int RR = 4;
    localparam int BH = 5;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       run_en;
    logic [1:0] mode;
    logic       inc_h, inc_m, inc_s;
    logic       blank_h, blank_m, blank_s;

    logic [8:0] sb_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] last_mode = 2'b00;
    int         since = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .BLINK_HALF  (BH),
        .TIMEOUT     (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .run_en  (run_en),
        .mode    (mode),
        .inc_h   (inc_h),
        .inc_m   (inc_m),
        .inc_s   (inc_s),
        .blank_h (blank_h),
        .blank_m (blank_m),
        .blank_s (blank_s)
    );

    // Vector layout: {mode, run_en, inc_h, inc_m, inc_s, blank_h, blank_m, blank_s}
    function automatic logic [8:0] build(input logic [1:0] m, input logic [2:0] inc_hms, input int j);
        logic ph;
        ph = ((j / BH) % 2) == 1;
        return {m, (m == 2'b00), inc_hms, ph && (m == 2'b01), ph && (m == 2'b10), ph && (m == 2'b11)};
    endfunction

    task automatic check_output(input string tag);
        logic [8:0] exp, act;
        act = {mode, run_en, inc_h, inc_m, inc_s, blank_h, blank_m, blank_s};
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, act);
        end else begin
            exp = sb_q.pop_front();
            assert (act === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", tag, act, exp);
            end
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic bm, input logic bi,
                                  input logic [1:0] exp_mode, input logic [2:0] exp_inc);
        @(negedge clk);
        btn_mode = bm;
        btn_inc  = bi;
        if (exp_mode != last_mode) since = 0;
        else since++;
        last_mode = exp_mode;
        sb_q.push_back(build(exp_mode, exp_inc, since));
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    task automatic press(input string tag, input logic [1:0] exp_mode);
        apply_stimulus(tag, 1'b1, 1'b0, exp_mode, 3'b000);
        apply_stimulus(tag, 1'b0, 1'b0, exp_mode, 3'b000);
    endtask

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.push_back(build(2'b00, 3'b000, 0));
        check_output("reset_state");
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) apply_stimulus("idle_run", 1'b0, 1'b0, 2'b00, 3'b000);

        // Mode cycling
        press("mode_seq", 2'b01);
        press("mode_seq", 2'b10);
        press("mode_seq", 2'b11);
        press("mode_seq", 2'b00);

        // Single increment in SET_M, then ignored in RUN
        press("to_set_m", 2'b01);
        press("to_set_m", 2'b10);
        apply_stimulus("single_inc_m", 1'b0, 1'b1, 2'b10, 3'b010);
        for (int i = 0; i < 3; i++) apply_stimulus("after_inc_m", 1'b0, 1'b0, 2'b10, 3'b000);
        press("to_run", 2'b11);
        press("to_run", 2'b00);
        apply_stimulus("inc_in_run", 1'b0, 1'b1, 2'b00, 3'b000);
        for (int i = 0; i < 2; i++) apply_stimulus("after_run_inc", 1'b0, 1'b0, 2'b00, 3'b000);

        // Hold-to-repeat in SET_H
        press("to_set_h", 2'b01);
        for (int k = 0; k <= 20; k++) begin
            apply_stimulus("repeat_h", 1'b0, 1'b1, 2'b01,
                           (k == 0 || k == RD || k == RD + RR || k == RD + 2 * RR || k == RD + 3 * RR)
                           ? 3'b100 : 3'b000);
        end
        for (int i = 0; i < 3; i++) apply_stimulus("repeat_release", 1'b0, 1'b0, 2'b01, 3'b000);

        // Blink in SET_S and idle timeout back to RUN
        press("to_set_s", 2'b10);
        apply_stimulus("blink_s", 1'b1, 1'b0, 2'b11, 3'b000);
        for (int j = 1; j <= TO; j++) apply_stimulus("blink_s", 1'b0, 1'b0, 2'b11, 3'b000);
        apply_stimulus("timeout", 1'b0, 1'b0, 2'b00, 3'b000);
        apply_stimulus("after_timeout", 1'b0, 1'b0, 2'b00, 3'b000);

        // Simultaneous mode and inc edges: mode wins and hold stays idle
        press("to_set_h2", 2'b01);
        apply_stimulus("mode_beats_inc", 1'b1, 1'b1, 2'b10, 3'b000);
        for (int i = 0; i < 10; i++) apply_stimulus("hold_idle", 1'b0, 1'b1, 2'b10, 3'b000);
        apply_stimulus("inc_release", 1'b0, 1'b0, 2'b10, 3'b000);

        // Reset in the middle of a repeat hold
        apply_stimulus("pre_reset_inc", 1'b0, 1'b1, 2'b10, 3'b010);
        for (int i = 0; i < 5; i++) apply_stimulus("pre_reset_hold", 1'b0, 1'b1, 2'b10, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb_q.push_back(build(2'b00, 3'b000, 0));
        check_output("reset_mid_repeat");
        @(negedge clk);
        reset = 1'b0;
        last_mode = 2'b00;
        for (int i = 0; i < 15; i++) apply_stimulus("post_reset", 1'b0, 1'b1, 2'b00, 3'b000);
        apply_stimulus("post_reset_release", 1'b0, 1'b0, 2'b00, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
